// File: rtl/pipe_ctrl_if.sv
// Pipeline hazard-control bundle: decode/execute/memory hazard sources in,
// stage enables, flushes, bubble, error, state and stall counter out.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       D_ADDR1;
    logic [4:0]       D_ADDR2;
    logic             D_USES_RS1;
    logic             D_USES_RS2;
    logic [4:0]       E_WADDR;
    logic             E_MEM_READ;
    logic             E_BRANCH_TAKEN;
    logic             MEM_REQ;
    logic             MEM_READY;
    logic             PC_EN;
    logic             FD_EN;
    logic             DE_EN;
    logic             EM_EN;
    logic             FD_FLUSH;
    logic             DE_FLUSH;
    logic             MW_BUBBLE;
    logic             ERR;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] STALL_CNT;

    modport master (
        output D_ADDR1, D_ADDR2, D_USES_RS1, D_USES_RS2,
        output E_WADDR, E_MEM_READ, E_BRANCH_TAKEN,
        output MEM_REQ, MEM_READY,
        input  PC_EN, FD_EN, DE_EN, EM_EN,
        input  FD_FLUSH, DE_FLUSH, MW_BUBBLE,
        input  ERR, STATE, STALL_CNT
    );

    modport slave (
        input  D_ADDR1, D_ADDR2, D_USES_RS1, D_USES_RS2,
        input  E_WADDR, E_MEM_READ, E_BRANCH_TAKEN,
        input  MEM_REQ, MEM_READY,
        output PC_EN, FD_EN, DE_EN, EM_EN,
        output FD_FLUSH, DE_FLUSH, MW_BUBBLE,
        output ERR, STATE, STALL_CNT
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// freeze with timeout. Ports: CLK, RST_N (async low), bus (slave modport).
module pipe_ctrl #(
    parameter int LU_CYCLES   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    state_e           rule_st;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q;

    logic lu, mw, mw_eff, rule_on;
    logic pc_en, fd_en, de_en, em_en;
    logic fd_fl, de_fl, bub;

    assign lu = bus.E_MEM_READ && (bus.E_WADDR != 5'd0) &&
                ((bus.D_USES_RS1 && (bus.D_ADDR1 == bus.E_WADDR)) ||
                 (bus.D_USES_RS2 && (bus.D_ADDR2 == bus.E_WADDR)));
    assign mw = bus.MEM_REQ && !bus.MEM_READY;

    // A released MEM_WAIT replays the rules of the state it interrupted,
    // with the memory hazard considered resolved.
    assign rule_st = (state_q == MEM_WAIT) ? ret_q : state_q;
    assign rule_on = (state_q == RUN) || (state_q == LU_STALL) ||
                     ((state_q == MEM_WAIT) && bus.MEM_READY);
    assign mw_eff  = mw && (state_q != MEM_WAIT);

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        lu_cnt_d = lu_cnt_q;
        wait_d   = wait_q;
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        em_en    = 1'b0;
        fd_fl    = 1'b0;
        de_fl    = 1'b0;
        bub      = 1'b0;
        if (state_q == ERROR) begin
            bub = 1'b1;
        end else if (!rule_on) begin
            bub    = 1'b1;
            wait_d = wait_q + 8'd1;
            if (wait_q == 8'(MEM_TIMEOUT)) state_d = ERROR;
        end else if (mw_eff) begin
            bub     = 1'b1;
            state_d = MEM_WAIT;
            ret_d   = state_q;
            wait_d  = 8'd1;
        end else if (bus.E_BRANCH_TAKEN) begin
            {pc_en, fd_en, de_en, em_en} = 4'b1111;
            fd_fl    = 1'b1;
            de_fl    = 1'b1;
            state_d  = RUN;
            lu_cnt_d = 2'd0;
        end else if (rule_st == LU_STALL) begin
            {de_en, em_en, de_fl} = 3'b111;
            lu_cnt_d = lu_cnt_q - 2'd1;
            state_d  = (lu_cnt_q == 2'd1) ? RUN : LU_STALL;
        end else if (lu) begin
            {de_en, em_en, de_fl} = 3'b111;
            if (LU_CYCLES == 1) begin
                state_d = RUN;
            end else begin
                state_d  = LU_STALL;
                lu_cnt_d = 2'(LU_CYCLES - 1);
            end
        end else begin
            {pc_en, fd_en, de_en, em_en} = 4'b1111;
            state_d = RUN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            lu_cnt_q <= 2'd0;
            wait_q   <= 8'd0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            lu_cnt_q <= lu_cnt_d;
            wait_q   <= wait_d;
            if (!pc_en && (state_q != ERROR) && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    // Enables and flushes are forced low for as long as reset is held.
    assign bus.PC_EN     = RST_N && pc_en;
    assign bus.FD_EN     = RST_N && fd_en;
    assign bus.DE_EN     = RST_N && de_en;
    assign bus.EM_EN     = RST_N && em_en;
    assign bus.FD_FLUSH  = RST_N && fd_fl;
    assign bus.DE_FLUSH  = RST_N && de_fl;
    assign bus.MW_BUBBLE = RST_N && bub;
    assign bus.ERR       = RST_N && (state_q == ERROR);
    assign bus.STATE     = state_q;
    assign bus.STALL_CNT = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl with directed hazard scenarios.
// A behavioural model predicts each cycle's outputs; a monitor compares.
module tb_pipe_ctrl;
    localparam int LUC = 2;
    localparam int TO  = 4;
    localparam int CW  = 4;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] a1;
        logic [4:0] a2;
        logic       u1;
        logic       u2;
        logic [4:0] ew;
        logic       emr;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } stim_t;

    typedef struct packed {
        logic          pc;
        logic          fd;
        logic          de;
        logic          em;
        logic          fdf;
        logic          def;
        logic          bub;
        logic          err;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sbq[$];

    // reference model state
    int m_mode = 0;
    int m_left = 0;
    int m_waited = 0;
    int m_ret = 0;
    int m_stalls = 0;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(
        .LU_CYCLES  (LUC),
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    function automatic stim_t mk(input logic r, input logic [4:0] a1,
                                 input logic [4:0] a2, input logic u1,
                                 input logic u2, input logic [4:0] ew,
                                 input logic emr, input logic br,
                                 input logic mreq, input logic mrdy);
        stim_t s;
        s = '{r, a1, a2, u1, u2, ew, emr, br, mreq, mrdy};
        return s;
    endfunction

    // Mode numbers follow the STATE encoding: 0 run, 1 load-use stall,
    // 2 memory wait, 3 error.
    task automatic model(input stim_t s, output exp_t e);
        bit lu, mw, stall;
        int src, nxt;
        e = '0;
        if (!s.rst_n) begin
            m_mode = 0; m_left = 0; m_waited = 0;
            m_ret = 0; m_stalls = 0;
            return;
        end
        lu = s.emr && s.ew != 0 &&
             ((s.u1 && s.a1 == s.ew) || (s.u2 && s.a2 == s.ew));
        mw = s.mreq && !s.mrdy;
        e.st  = 2'(m_mode);
        e.cnt = CW'(m_stalls);
        e.err = (m_mode == 3);
        nxt = m_mode;
        stall = 0;
        if (m_mode == 3) begin
            e.bub = 1;
        end else if (m_mode == 2 && !s.mrdy) begin
            e.bub = 1;
            if (m_waited == TO) nxt = 3;
            m_waited++;
        end else begin
            src = (m_mode == 2) ? m_ret : m_mode;
            if (m_mode != 2 && mw) begin
                e.bub = 1;
                m_ret = m_mode;
                m_waited = 1;
                nxt = 2;
            end else if (s.br) begin
                {e.pc, e.fd, e.de, e.em, e.fdf, e.def} = 6'b111111;
                m_left = 0;
                nxt = 0;
            end else if (src == 1 || lu) begin
                {e.de, e.em, e.def} = 3'b111;
                if (src == 1) begin
                    m_left--;
                    nxt = (m_left == 0) ? 0 : 1;
                end else begin
                    m_left = LUC - 1;
                    nxt = (m_left == 0) ? 0 : 1;
                end
            end else begin
                {e.pc, e.fd, e.de, e.em} = 4'b1111;
                nxt = 0;
            end
        end
        if (!e.pc && m_mode != 3 && m_stalls < (1 << CW) - 1) m_stalls++;
        m_mode = nxt;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge CLK);
        cyc++;
        RST_N              = s.rst_n;
        bus.D_ADDR1        = s.a1;
        bus.D_ADDR2        = s.a2;
        bus.D_USES_RS1     = s.u1;
        bus.D_USES_RS2     = s.u2;
        bus.E_WADDR        = s.ew;
        bus.E_MEM_READ     = s.emr;
        bus.E_BRANCH_TAKEN = s.br;
        bus.MEM_REQ        = s.mreq;
        bus.MEM_READY      = s.mrdy;
        model(s, e);
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: compares the DUT against the oldest queued prediction
    initial begin
        exp_t e, a;
        forever begin
            @(negedge CLK);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = {bus.PC_EN, bus.FD_EN, bus.DE_EN, bus.EM_EN,
                     bus.FD_FLUSH, bus.DE_FLUSH, bus.MW_BUBBLE,
                     bus.ERR, bus.STATE, bus.STALL_CNT};
                n_chk++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL sb cycle %0d: got %b expected %b",
                             cyc, a, e);
                end
            end
        end
    end

    initial begin
        stim_t idle, rst, lus, x0, mwx, all3, rel;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lus  = mk(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        x0   = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        mwx  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        all3 = mk(1, 5, 0, 1, 0, 5, 1, 1, 1, 0);
        rel  = mk(1, 5, 0, 1, 0, 5, 1, 1, 1, 1);
        {bus.D_ADDR1, bus.D_ADDR2, bus.D_USES_RS1, bus.D_USES_RS2} = '0;
        {bus.E_WADDR, bus.E_MEM_READ, bus.E_BRANCH_TAKEN} = '0;
        {bus.MEM_REQ, bus.MEM_READY} = '0;

        // reset state
        drive(rst); drive(rst);
        #2;
        chk("rst_state", int'(bus.STATE), 0);
        chk("rst_pc_en", int'(bus.PC_EN), 0);
        chk("rst_cnt", int'(bus.STALL_CNT), 0);

        // x0 never creates a load-use hazard
        drive(x0);
        #2;
        chk("x0_pc_en", int'(bus.PC_EN), 1);
        chk("x0_de_flush", int'(bus.DE_FLUSH), 0);

        // load-use with two bubble cycles
        drive(rst); drive(lus);
        #2;
        chk("lu0_pc_en", int'(bus.PC_EN), 0);
        chk("lu0_de_flush", int'(bus.DE_FLUSH), 1);
        drive(idle);
        #2;
        chk("lu1_state", int'(bus.STATE), 1);
        chk("lu1_pc_en", int'(bus.PC_EN), 0);
        drive(idle);
        #2;
        chk("lu2_state", int'(bus.STATE), 0);
        chk("lu2_pc_en", int'(bus.PC_EN), 1);
        chk("lu_cnt", int'(bus.STALL_CNT), 2);

        // memory wait of three frozen cycles
        drive(rst);
        repeat (3) drive(mwx);
        #2;
        chk("mw_state", int'(bus.STATE), 2);
        chk("mw_bubble", int'(bus.MW_BUBBLE), 1);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        #2;
        chk("mw_rel_pc_en", int'(bus.PC_EN), 1);
        drive(idle);
        #2;
        chk("mw_cnt", int'(bus.STALL_CNT), 3);

        // memory wait outranks branch, branch replays on release
        drive(rst); drive(all3);
        #2;
        chk("pri_pc_en", int'(bus.PC_EN), 0);
        chk("pri_fd_flush", int'(bus.FD_FLUSH), 0);
        drive(rel);
        #2;
        chk("pri_rel_fd_flush", int'(bus.FD_FLUSH), 1);
        chk("pri_rel_de_flush", int'(bus.DE_FLUSH), 1);
        chk("pri_rel_pc_en", int'(bus.PC_EN), 1);

        // timeout to error, sticky until reset
        drive(rst);
        repeat (5) drive(mwx);
        #2;
        chk("to_pre_state", int'(bus.STATE), 2);
        drive(mwx);
        #2;
        chk("to_state", int'(bus.STATE), 3);
        chk("to_err", int'(bus.ERR), 1);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        #2;
        chk("to_sticky", int'(bus.STATE), 3);
        drive(rst);
        drive(idle);
        #2;
        chk("to_clr_state", int'(bus.STATE), 0);
        chk("to_clr_err", int'(bus.ERR), 0);

        // stall counter saturation
        drive(rst);
        repeat (20) drive(lus);
        drive(idle);
        #2;
        chk("sat_cnt", int'(bus.STALL_CNT), 15);

        // randomized traffic
        drive(rst);
        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            s.rst_n = ($urandom_range(39) != 0);
            s.a1    = 5'($urandom_range(3));
            s.a2    = 5'($urandom_range(3));
            s.u1    = 1'($urandom_range(1));
            s.u2    = 1'($urandom_range(1));
            s.ew    = 5'($urandom_range(3));
            s.emr   = ($urandom_range(2) != 0);
            s.br    = ($urandom_range(7) == 0);
            s.mreq  = ($urandom_range(3) == 0);
            s.mrdy  = ($urandom_range(2) != 0);
            drive(s);
        end

        repeat (3) @(negedge CLK);
        #3;
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter LU_CYCLES, default 1, load-to-use bubble count (legal 1..3).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles before error (legal 1..255).
REQ-003 SHALL have parameter CNT_W, default 16, STALL_CNT width.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
  CLK  in  1  rising-edge clock
  RST_N  in  1  asynchronous active-low reset
  D_ADDR1  in  5  decode rs1
  D_ADDR2  in  5  decode rs2
  D_USES_RS1  in  1  decode instr reads rs1
  D_USES_RS2  in  1  decode instr reads rs2
  E_WADDR  in  5  execute rd
  E_MEM_READ  in  1  execute instr is a load
  E_BRANCH_TAKEN  in  1  execute redirects PC
  MEM_REQ  in  1  memory stage access active
  MEM_READY  in  1  data memory ack
  PC_EN  out  1  PC register enable
  FD_EN  out  1  IF/ID enable
  DE_EN  out  1  ID/EX enable
  EM_EN  out  1  EX/MEM enable
  FD_FLUSH  out  1  IF/ID clear to NOP
  DE_FLUSH  out  1  ID/EX clear to NOP
  MW_BUBBLE  out  1  MEM/WB load NOP
  ERR  out  1  sticky memory timeout
  STATE  out  2  FSM state
  STALL_CNT  out  CNT_W  stall-cycle counter

Function
REQ-005 SHALL define LU = E_MEM_READ & E_WADDR!=0 & ((D_USES_RS1 & D_ADDR1==E_WADDR) | (D_USES_RS2 & D_ADDR2==E_WADDR)).
REQ-006 SHALL define MW = MEM_REQ & !MEM_READY.
REQ-007 SHALL encode STATE: RUN=0, LU_STALL=1, MEM_WAIT=2, ERROR=3.
REQ-008 SHALL compute outputs combinationally from state and inputs; state, counters and the return register update on CLK rising edge only.
REQ-009 SHALL apply priority MW > E_BRANCH_TAKEN > LU in RUN and LU_STALL.
REQ-010 RUN, no event: all enables 1, flushes 0, MW_BUBBLE 0.
REQ-011 RUN/LU_STALL with MW: all enables 0, MW_BUBBLE 1; next MEM_WAIT; return register <= current state; wait counter <= 1.
REQ-012 RUN/LU_STALL with E_BRANCH_TAKEN (no MW): enables 1, FD_FLUSH=1, DE_FLUSH=1; next RUN; LU bubble count discarded.
REQ-013 RUN with LU (no MW, no branch): PC_EN=0, FD_EN=0, DE_FLUSH=1, DE_EN=1, EM_EN=1; if LU_CYCLES==1 next RUN, else next LU_STALL with lu_cnt <= LU_CYCLES-1.
REQ-014 LU_STALL (no MW, no branch): outputs as REQ-013; lu_cnt decrements; when lu_cnt==1, next RUN.
REQ-015 MEM_WAIT with MEM_READY=0: outputs as REQ-011; wait counter increments; when counter == MEM_TIMEOUT, next ERROR.
REQ-016 MEM_WAIT with MEM_READY=1: outputs equal those of the return state with MW treated false; next state as that return-state rule dictates; lu_cnt held throughout MEM_WAIT.
REQ-017 E_BRANCH_TAKEN and LU SHALL be ignored while MEM_WAIT and MEM_READY=0.
REQ-018 ERROR: all enables 0, flushes 0, MW_BUBBLE 1, ERR=1; remain until reset.
REQ-019 STALL_CNT increments each cycle PC_EN=0 in RUN, LU_STALL or MEM_WAIT; saturates at all-ones; frozen in ERROR.

Reset
REQ-020 RST_N=0 SHALL immediately force STATE=RUN, lu_cnt=0, wait counter=0, return register=RUN, STALL_CNT=0, ERR=0.
REQ-021 While RST_N=0 all enables, flushes and MW_BUBBLE SHALL be 0; reset mid-MEM_WAIT or mid-ERROR SHALL abandon the operation.
REQ-022 First edge after RST_N rises SHALL evaluate RUN rules.

Verification
REQ-023 Load-use: LU_CYCLES=2, E_MEM_READ=1, E_WADDR=5, D_ADDR1=5, D_USES_RS1=1 one cycle -> 2 cycles PC_EN=0, DE_FLUSH=1, STATE 0->1->0, STALL_CNT=2.
REQ-024 x0 exemption: E_WADDR=0, D_ADDR1=0, E_MEM_READ=1 -> no stall, all enables 1.
REQ-025 Memory wait: MEM_REQ=1, MEM_READY=0 for 3 cycles then 1 -> 3 frozen cycles, MW_BUBBLE=1, STATE=2, then RUN with enables 1; STALL_CNT=3.
REQ-026 Priority: MW, E_BRANCH_TAKEN, LU all asserted -> MEM_WAIT freeze; after MEM_READY, branch flush (FD_FLUSH=DE_FLUSH=1) in the release cycle.
REQ-027 Timeout: MEM_TIMEOUT=4, MEM_READY held 0 -> STATE=3, ERR=1 after 4 wait cycles; MEM_READY=1 then has no effect; RST_N pulse -> STATE=0, ERR=0.
REQ-028 Saturation: CNT_W=4, 20 stall cycles -> STALL_CNT=15.
